chess_clock_core: RTL and testbench

- Parametrised, clocked successor to the combinational set/display data selector of the chess timer.
- Holds per-player remaining time as minutes:seconds registers and loads them from the set-time value.
- Counts down the active player on a 1 Hz tick, applies a Fischer increment and rotates turn on each turn-end press, and flags a player whose time expires.
- Sits between the button debouncers/1 Hz prescaler and the display multiplexer; data_out feeds the display path directly.

---
 rtl/chess_clock_core.sv | 164 ++++++++++++++++
 tb/tb_chess_clock_core.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_clock_core.sv
// Chess clock core: per-player min:sec countdown with Fischer increment, turn rotation
// and expiry flags. All outputs come straight from registers.
module chess_clock_core #(
   parameter int NUM_PLAYERS = 2,
   parameter int MIN_W       = 6,
   parameter int SEC_W       = 6,
   parameter int MAX_MIN     = 59,
   parameter int PW          = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               tick_1hz,
   input  logic                               set_time,
   input  logic [MIN_W-1:0]                   time_in,
   input  logic [SEC_W-1:0]                   inc_in,
   input  logic                               start,
   input  logic                               pause,
   input  logic                               turn_end,
   output logic [NUM_PLAYERS*(MIN_W+SEC_W)-1:0] data_out,
   output logic [PW-1:0]                      active_player,
   output logic [NUM_PLAYERS-1:0]             flag,
   output logic                               running,
   output logic                               done
);

   localparam int SLOT_W = MIN_W + SEC_W;
   localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);
   localparam logic [MIN_W:0]   MAX_MIN_X = (MIN_W+1)'(MAX_MIN);
   localparam logic [SEC_W-1:0] SEC_MAX   = SEC_W'(59);
   localparam logic [SEC_W:0]   SIXTY     = (SEC_W+1)'(60);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, FLAGGED} state_t;

   state_t                 state_reg, state_next;
   logic [MIN_W-1:0]       min_reg [NUM_PLAYERS];
   logic [SEC_W-1:0]       sec_reg [NUM_PLAYERS];
   logic [PW-1:0]          active_reg;
   logic [NUM_PLAYERS-1:0] flag_reg;
   logic                   done_reg;

   logic             run_ev, do_tick, do_turn, expire, turn_ok, upd_active;
   logic [MIN_W-1:0] act_min, dec_min, base_min, inc_min, new_min, load_min;
   logic [SEC_W-1:0] act_sec, dec_sec, base_sec, inc_sec, new_sec, inc_val;
   logic [SEC_W:0]   sec_sum;
   logic [MIN_W:0]   min_sum;
   logic             carry;

   // Counting events only happen in RUN and only when no higher-priority pulse is present.
   assign run_ev     = (state_reg == RUN) && !set_time && !pause;
   assign do_tick    = run_ev && tick_1hz;
   assign do_turn    = run_ev && turn_end;
   assign upd_active = do_tick || do_turn;

   assign act_min  = min_reg[active_reg];
   assign act_sec  = sec_reg[active_reg];
   assign load_min = (time_in > MAX_MIN_V) ? MAX_MIN_V : time_in;
   assign inc_val  = (inc_in > SEC_MAX) ? SEC_MAX : inc_in;

   // Decrement of the active player; 0:00 stays 0:00.
   always_comb begin
      dec_min = act_min;
      dec_sec = act_sec;
      if (act_sec != '0) begin
         dec_sec = act_sec - SEC_W'(1);
      end else if (act_min != '0) begin
         dec_min = act_min - MIN_W'(1);
         dec_sec = SEC_MAX;
      end
   end

   assign base_min = do_tick ? dec_min : act_min;
   assign base_sec = do_tick ? dec_sec : act_sec;
   // Reaching (or already sitting at) 0:00 on a tick flags the player.
   assign expire   = do_tick && (dec_min == '0) && (dec_sec == '0);
   assign turn_ok  = do_turn && !expire;

   // Fischer increment applied on top of the (possibly decremented) time.
   always_comb begin
      sec_sum = {1'b0, base_sec} + {1'b0, inc_val};
      carry   = (sec_sum >= SIXTY);
      inc_sec = carry ? SEC_W'(sec_sum - SIXTY) : SEC_W'(sec_sum);
      min_sum = {1'b0, base_min} + {{MIN_W{1'b0}}, carry};
      inc_min = MIN_W'(min_sum);
      if (min_sum > MAX_MIN_X) begin
         inc_min = MAX_MIN_V;
         inc_sec = SEC_MAX;
      end
   end

   assign new_min = turn_ok ? inc_min : base_min;
   assign new_sec = turn_ok ? inc_sec : base_sec;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            min_reg[p] <= '0;
            sec_reg[p] <= '0;
         end
         flag_reg   <= '0;
         active_reg <= '0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= set_time;
         if (set_time) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
               min_reg[p] <= load_min;
               sec_reg[p] <= '0;
            end
            flag_reg   <= '0;
            active_reg <= '0;
         end else begin
            if (upd_active) begin
               min_reg[active_reg] <= new_min;
               sec_reg[active_reg] <= new_sec;
            end
            if (expire) begin
               flag_reg[active_reg] <= 1'b1;
            end
            if (turn_ok) begin
               active_reg <= (active_reg == PW'(NUM_PLAYERS - 1)) ? '0 : active_reg + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (set_time) begin
         state_next = IDLE;
      end else if (pause) begin
         if (state_reg == RUN) begin
            state_next = PAUSED;
         end
      end else if (start && (state_reg == IDLE || state_reg == PAUSED)) begin
         state_next = RUN;
      end else if (expire) begin
         state_next = FLAGGED;
      end
   end

   always_comb begin
      running = (state_reg == RUN);
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_slot
         assign data_out[(NUM_PLAYERS-gi)*SLOT_W-1 -: SLOT_W] = {min_reg[gi], sec_reg[gi]};
      end
   endgenerate

   assign active_player = active_reg;
   assign flag          = flag_reg;
   assign done          = done_reg;

endmodule

// File: tb/tb_chess_clock_core.sv
// Scoreboard bench for chess_clock_core: a total-seconds reference model predicts each
// cycle's outputs; milestone values from the test plan are also checked as constants.
module tb_chess_clock_core;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick_1hz = 1'b0, set_time = 1'b0, start = 1'b0, pause = 1'b0, turn_end = 1'b0;
   logic [5:0]  time_in = 6'd0, inc_in = 6'd0;
   logic [23:0] data_out;
   logic [0:0]  active_player;
   logic [1:0]  flag;
   logic        running, done;

   int checks = 0;
   int errors = 0;

   chess_clock_core dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .set_time(set_time),
      .time_in(time_in), .inc_in(inc_in), .start(start), .pause(pause),
      .turn_end(turn_end), .data_out(data_out), .active_player(active_player),
      .flag(flag), .running(running), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] data;
      logic        act;
      logic [1:0]  flg;
      logic        run;
      logic        dn;
   } exp_t;

   exp_t sb[$];

   // Reference model: remaining time kept as total seconds per player.
   int m_t[2] = '{0, 0};
   int m_act = 0;
   bit [1:0] m_flg = 2'b00;
   int m_st = 0;   // 0 idle, 1 run, 2 paused, 3 flagged
   bit m_dn = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] slot(input int v);
      return {6'(v / 60), 6'(v % 60)};
   endfunction

   task automatic model_update(input bit ts, input bit tk, input bit te,
                               input bit sa, input bit pa, input bit rs);
      int v;
      int inc;
      bit fl;
      m_dn = ts && !rs;
      if (rs) begin
         m_t[0] = 0; m_t[1] = 0; m_act = 0; m_flg = 2'b00; m_st = 0;
      end else if (ts) begin
         v = (int'(time_in) > 59) ? 59 : int'(time_in);
         m_t[0] = v * 60; m_t[1] = v * 60; m_act = 0; m_flg = 2'b00; m_st = 0;
      end else if (pa) begin
         if (m_st == 1) m_st = 2;
      end else if (sa && (m_st == 0 || m_st == 2)) begin
         m_st = 1;
      end else if (m_st == 1 && (tk || te)) begin
         v = m_t[m_act];
         fl = 1'b0;
         if (tk) begin
            if (v > 0) v = v - 1;
            if (v == 0) fl = 1'b1;
         end
         if (fl) begin
            m_t[m_act] = v;
            m_flg[m_act] = 1'b1;
            m_st = 3;
         end else if (te) begin
            inc = (int'(inc_in) > 59) ? 59 : int'(inc_in);
            v = v + inc;
            if (v > 59 * 60 + 59) v = 59 * 60 + 59;
            m_t[m_act] = v;
            m_act = (m_act + 1) % 2;
         end else begin
            m_t[m_act] = v;
         end
      end
   endtask

   task automatic step(input bit ts, input bit tk, input bit te,
                       input bit sa, input bit pa, input bit rs);
      exp_t e;
      @(negedge clk);
      rst = rs; set_time = ts; tick_1hz = tk; turn_end = te; start = sa; pause = pa;
      model_update(ts, tk, te, sa, pa, rs);
      e.data = {slot(m_t[0]), slot(m_t[1])};
      e.act  = m_act[0];
      e.flg  = m_flg;
      e.run  = (m_st == 1);
      e.dn   = m_dn;
      sb.push_back(e);
      @(posedge clk);
      #1;
      rst = 1'b0; set_time = 1'b0; tick_1hz = 1'b0; turn_end = 1'b0; start = 1'b0; pause = 1'b0;
      e = sb.pop_front();
      $display("t=%0t in(rst=%0b ld=%0b tk=%0b te=%0b st=%0b pa=%0b) data=%h act=%0d flag=%b run=%0b done=%0b",
               $time, rs, ts, tk, te, sa, pa, data_out, active_player, flag, running, done);
      check_val("sb_data", 32'(data_out), 32'(e.data));
      check_val("sb_act", 32'(active_player), 32'(e.act));
      check_val("sb_flag", 32'(flag), 32'(e.flg));
      check_val("sb_run", 32'(running), 32'(e.run));
      check_val("sb_done", 32'(done), 32'(e.dn));
   endtask

   task automatic idle();               step(0, 0, 0, 0, 0, 0); endtask
   task automatic do_load();            step(1, 0, 0, 0, 0, 0); endtask
   task automatic do_start();           step(0, 0, 0, 1, 0, 0); endtask
   task automatic do_pause();           step(0, 0, 0, 0, 1, 0); endtask
   task automatic do_turn();            step(0, 0, 1, 0, 0, 0); endtask
   task automatic do_reset();           step(0, 0, 0, 0, 0, 1); endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset state, then start with all-zero times: first tick flags player 0
      do_reset();
      do_reset();
      check_val("rst_data", 32'(data_out), 32'h0);
      check_val("rst_run", 32'(running), 32'h0);
      do_start();
      check_val("zero_start_run", 32'(running), 32'h1);
      ticks(1);
      check_val("zero_tick_flag", 32'(flag), 32'b01);

      // Reset and load
      time_in = 6'd5;
      do_load();
      check_val("load5_data", 32'(data_out), 32'({6'd5, 6'd0, 6'd5, 6'd0}));
      check_val("load5_done", 32'(done), 32'h1);
      idle();
      check_val("load5_done_low", 32'(done), 32'h0);
      check_val("load5_act", 32'(active_player), 32'h0);

      // Countdown with borrow
      time_in = 6'd1;
      do_load();
      do_start();
      ticks(3);
      check_val("cd_p0_057", 32'(data_out[23:12]), 32'({6'd0, 6'd57}));
      check_val("cd_p1_100", 32'(data_out[11:0]), 32'({6'd1, 6'd0}));
      ticks(57);
      check_val("cd_p0_zero", 32'(data_out[23:12]), 32'h0);
      check_val("cd_flag", 32'(flag), 32'b01);
      check_val("cd_run", 32'(running), 32'h0);
      ticks(2);
      do_turn();
      do_start();
      check_val("cd_frozen", 32'(data_out), 32'({6'd0, 6'd0, 6'd1, 6'd0}));

      // Increment, carry and rotation
      time_in = 6'd1; inc_in = 6'd10;
      do_load();
      do_start();
      ticks(55);
      check_val("inc_p0_005", 32'(data_out[23:12]), 32'({6'd0, 6'd5}));
      do_turn();
      check_val("inc_p0_015", 32'(data_out[23:12]), 32'({6'd0, 6'd15}));
      check_val("inc_act1", 32'(active_player), 32'h1);
      ticks(1);
      check_val("inc_p1_059", 32'(data_out[11:0]), 32'({6'd0, 6'd59}));
      do_turn();
      check_val("inc_p1_carry", 32'(data_out[11:0]), 32'({6'd1, 6'd9}));
      check_val("inc_act0", 32'(active_player), 32'h0);

      // Saturation and clamping
      time_in = 6'd63; inc_in = 6'd63;
      do_load();
      check_val("sat_load", 32'(data_out), 32'({6'd59, 6'd0, 6'd59, 6'd0}));
      do_start();
      do_turn();
      check_val("sat_p0", 32'(data_out[23:12]), 32'({6'd59, 6'd59}));
      do_turn();
      check_val("sat_wrap_act", 32'(active_player), 32'h0);
      check_val("sat_p1", 32'(data_out[11:0]), 32'({6'd59, 6'd59}));

      // Simultaneous tick and turn_end
      time_in = 6'd1; inc_in = 6'd5;
      do_load();
      do_start();
      ticks(58);
      check_val("sim_p0_002", 32'(data_out[23:12]), 32'({6'd0, 6'd2}));
      step(0, 1, 1, 0, 0, 0);
      check_val("sim_p0_006", 32'(data_out[23:12]), 32'({6'd0, 6'd6}));
      check_val("sim_act1", 32'(active_player), 32'h1);
      do_turn();
      ticks(5);
      check_val("sim_p0_001", 32'(data_out[23:12]), 32'({6'd0, 6'd1}));
      step(0, 1, 1, 0, 0, 0);
      check_val("sim_flag_p0", 32'(data_out[23:12]), 32'h0);
      check_val("sim_flag", 32'(flag), 32'b01);
      check_val("sim_act_stay", 32'(active_player), 32'h0);

      // Pause, resume, priority and mid-run reload
      time_in = 6'd2;
      do_load();
      do_start();
      ticks(3);
      do_pause();
      ticks(3);
      check_val("pause_hold", 32'(data_out[23:12]), 32'({6'd1, 6'd57}));
      do_start();
      step(0, 1, 0, 0, 1, 0);
      check_val("pause_drop_tick", 32'(data_out[23:12]), 32'({6'd1, 6'd57}));
      do_start();
      ticks(1);
      check_val("resume", 32'(data_out[23:12]), 32'({6'd1, 6'd56}));
      time_in = 6'd3;
      step(1, 1, 0, 0, 0, 0);
      check_val("reload_data", 32'(data_out), 32'({6'd3, 6'd0, 6'd3, 6'd0}));
      check_val("reload_done", 32'(done), 32'h1);
      check_val("reload_idle", 32'(running), 32'h0);
      time_in = 6'd0;
      do_load();
      do_start();
      ticks(1);
      step(1, 0, 0, 1, 0, 0);
      check_val("reload_flag_clr", 32'(flag), 32'h0);
      do_start();
      ticks(1);
      check_val("rstf_flag", 32'(flag), 32'b01);
      do_reset();
      check_val("rstf_all", 32'({data_out, active_player, flag, running, done}), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
